// File: rtl/regfile16_pkg.sv
// regfile16_pkg: shared sizes and types for the register file.
package regfile16_pkg;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int WORD_W     = 64;
  localparam int ZR_IDX     = 15;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile16_if.sv
// regfile16_if: write port and two read ports of the register file.
interface regfile16_if #(parameter int WIDTH = 64);
  import regfile16_pkg::*;
  logic             RegWrite;
  reg_addr_t        WriteRegister;
  logic [WIDTH-1:0] WriteData;
  reg_addr_t        ReadRegister1;
  reg_addr_t        ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );
  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile16_decode.sv
// en_decode4_16: one-hot write-enable decode, all zero when disabled.
module en_decode4_16
  import regfile16_pkg::*;
(
  input  reg_addr_t             in_i,
  input  logic                  enable_i,
  output logic [NUM_REGS-1:0]   out_o
);
  // Ternary keeps an unknown address from leaking into the enables when disabled.
  always_comb out_o = enable_i ? (16'd1 << in_i) : '0;
endmodule

// File: rtl/regfile16_word.sv
// regfile_word: WIDTH-bit register with synchronous reset and load enable.
module regfile_word #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] word_q, word_d;
  always_comb word_d = rst ? '0 : (load_i ? d_i : word_q);
  always_ff @(posedge clk) word_q <= word_d;
  assign q_o = word_q;
endmodule

// File: rtl/regfile16.sv
// regfile16: 16 x WIDTH register file, one write port, two combinational read ports.
module regfile16
  import regfile16_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  regfile16_if.slave  bus
);
  localparam logic [NUM_REGS-1:0] WEN_MASK = ZERO_REG ? ~(16'd1 << ZR_IDX) : '1;
  logic [NUM_REGS-1:0] wen_raw, wen;
  logic [WIDTH-1:0]    words [NUM_REGS];
  logic                wr_ok, fwd1, fwd2, zr1, zr2;
  en_decode4_16 u_dec (
    .in_i     (bus.WriteRegister),
    .enable_i (bus.RegWrite),
    .out_o    (wen_raw)
  );
  assign wen = wen_raw & WEN_MASK;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
    regfile_word #(.WIDTH(WIDTH)) u_word (
      .clk    (clk),
      .rst    (reset),
      .load_i (wen[g]),
      .d_i    (bus.WriteData),
      .q_o    (words[g])
    );
  end
  // A write is only forwardable if it will actually land in a word this edge.
  always_comb begin
    wr_ok = BYPASS && bus.RegWrite && !reset && !(ZERO_REG && bus.WriteRegister == reg_addr_t'(ZR_IDX));
    fwd1  = wr_ok && bus.ReadRegister1 == bus.WriteRegister;
    fwd2  = wr_ok && bus.ReadRegister2 == bus.WriteRegister;
    zr1   = ZERO_REG && bus.ReadRegister1 == reg_addr_t'(ZR_IDX);
    zr2   = ZERO_REG && bus.ReadRegister2 == reg_addr_t'(ZR_IDX);
    bus.ReadData1 = fwd1 ? bus.WriteData : (zr1 ? '0 : words[bus.ReadRegister1]);
    bus.ReadData2 = fwd2 ? bus.WriteData : (zr2 ? '0 : words[bus.ReadRegister2]);
  end
endmodule

// File: tb/tb_regfile16.sv
// tb_regfile16: directed checks of a bypassing and a non-bypassing register file.
module tb_regfile16;
  import regfile16_pkg::*;
  typedef struct {
    logic      we;
    reg_addr_t wa;
    word_t     wd;
    reg_addr_t ra1;
    reg_addr_t ra2;
    word_t     b1, b2, n1, n2;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl [8];
  regfile16_if #(.WIDTH(64)) bif_b ();
  regfile16_if #(.WIDTH(64)) bif_n ();
  regfile16 #(.WIDTH(64), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(bif_b));
  regfile16 #(.WIDTH(64), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(bif_n));
  always #5 clk = ~clk;
  function automatic word_t sv(int k);
    return 64'hA5A5_0000_0000_0000 + word_t'(k);
  endfunction
  task automatic drive(logic r, logic we, reg_addr_t wa, word_t wd, reg_addr_t ra1, reg_addr_t ra2);
    reset = r;
    bif_b.RegWrite = we; bif_b.WriteRegister = wa; bif_b.WriteData = wd;
    bif_b.ReadRegister1 = ra1; bif_b.ReadRegister2 = ra2;
    bif_n.RegWrite = we; bif_n.WriteRegister = wa; bif_n.WriteData = wd;
    bif_n.ReadRegister1 = ra1; bif_n.ReadRegister2 = ra2;
  endtask
  task automatic chk(string nm, word_t act, word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk4(string nm, word_t b1, word_t b2, word_t n1, word_t n2);
    #1;
    chk({nm, " byp rd1"}, bif_b.ReadData1, b1);
    chk({nm, " byp rd2"}, bif_b.ReadData2, b2);
    chk({nm, " nob rd1"}, bif_n.ReadData1, n1);
    chk({nm, " nob rd2"}, bif_n.ReadData2, n2);
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'd15, 64'h1234, 4'd15, 4'd15, 64'h0, 64'h0, 64'h0, 64'h0};
    tbl[1] = '{1'b0, 4'd15, 64'h1234, 4'd15, 4'd15, 64'h0, 64'h0, 64'h0, 64'h0};
    tbl[2] = '{1'b1, 4'd3, 64'h11, 4'd3, 4'd4, 64'h11, sv(4), sv(3), sv(4)};
    tbl[3] = '{1'b1, 4'd3, 64'h22, 4'd3, 4'd3, 64'h22, 64'h22, 64'h11, 64'h11};
    tbl[4] = '{1'b0, 4'd5, 64'hDEAD, 4'd3, 4'd5, 64'h22, sv(5), 64'h22, sv(5)};
    tbl[5] = '{1'b0, 4'd5, 64'hDEAD, 4'd7, 4'd15, sv(7), 64'h0, sv(7), 64'h0};
    tbl[6] = '{1'b1, 4'd0, '1, 4'd0, 4'd1, '1, sv(1), sv(0), sv(1)};
    tbl[7] = '{1'b0, 4'd9, 64'h5, 4'd0, 4'd0, '1, '1, '1, '1};
    drive(1'b1, 1'b0, 4'd0, '0, 4'd0, 4'd1);
    step();
    drive(1'b0, 1'b0, 4'd0, '0, 4'd2, 4'd9);
    chk4("reset state", 64'h0, 64'h0, 64'h0, 64'h0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, reg_addr_t'(k), '1, 4'd0, 4'd0);
      step();
    end
    drive(1'b1, 1'b0, 4'd0, '0, 4'd0, 4'd0);
    step();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, reg_addr_t'(k), '0, reg_addr_t'(k), reg_addr_t'(15 - k));
      chk4($sformatf("cleared r%0d", k), 64'h0, 64'h0, 64'h0, 64'h0);
    end
    drive(1'b1, 1'b1, 4'd7, 64'hBEEF, 4'd7, 4'd7);
    chk4("reset vs write during", 64'h0, 64'h0, 64'h0, 64'h0);
    step();
    drive(1'b0, 1'b0, 4'd7, 64'hBEEF, 4'd7, 4'd7);
    chk4("reset vs write after", 64'h0, 64'h0, 64'h0, 64'h0);
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, 1'b1, reg_addr_t'(k), sv(k), 4'd15, 4'd15);
      step();
    end
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, 1'b0, 4'd0, '0, reg_addr_t'(k), reg_addr_t'(14 - k));
      chk4($sformatf("sweep r%0d", k), sv(k), sv(14 - k), sv(k), sv(14 - k));
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2);
      chk4($sformatf("vec%0d", i), tbl[i].b1, tbl[i].b2, tbl[i].n1, tbl[i].n2);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'd5, 64'hDEAD, 4'd5, 4'd3);
      chk4($sformatf("wdis cyc%0d", i), sv(5), 64'h22, sv(5), 64'h22);
      step();
    end
    drive(1'b0, 1'b0, 4'bxxxx, 64'hDEAD, 4'd5, 4'd6);
    step();
    drive(1'b0, 1'b0, 4'd0, '0, 4'd5, 4'd6);
    chk4("x addr no write", sv(5), sv(6), sv(5), sv(6));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
